// File: rtl/taxi_sfp_link_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : taxi_sfp_link_ctrl
// Brief  : SFP+ cage bring-up and link supervisor. Define
//          TAXI_SFP_CTRL_LOS_CHECK_EN to qualify the link with sfp_los.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module taxi_sfp_link_ctrl #(
  parameter int unsigned DEBOUNCE_CYC     = 1000000,
  parameter int unsigned TX_EN_CYC        = 12500,
  parameter int unsigned RST_CYC          = 125,
  parameter int unsigned LOCK_TIMEOUT_CYC = 12500000,
  parameter int unsigned RETRY_CYC        = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] rate_sel,
  input  logic       sfp_npres,
  input  logic       sfp_los,
  input  logic       pll_locked,
  input  logic       rx_block_lock,
  output logic       sfp_tx_disable,
  output logic [1:0] sfp_rs,
  output logic       xcvr_rst,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] fault_cnt,
  output logic [1:0] led
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_TX_EN     = 3'd2,
    ST_XCVR_RST  = 3'd3,
    ST_LOCK_WAIT = 3'd4,
    ST_LINK_UP   = 3'd5,
    ST_HOLDOFF   = 3'd6
  } state_t;

  localparam logic [31:0] c_deb_load   = DEBOUNCE_CYC - 32'd1;
  localparam logic [31:0] c_tx_load    = TX_EN_CYC - 32'd1;
  localparam logic [31:0] c_rst_load   = RST_CYC - 32'd1;
  localparam logic [31:0] c_lock_load  = LOCK_TIMEOUT_CYC - 32'd1;
  localparam logic [31:0] c_retry_load = RETRY_CYC - 32'd1;

  logic [1:0]  r_pres_sync, r_lock_sync, r_blk_sync;
  logic        w_present, w_ok;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic        w_cnt_zero, w_fault_inc;
  logic        r_tx_disable, r_xcvr_rst, r_link_up, r_mod_present;
  logic [1:0]  r_sfp_rs;
  logic [7:0]  r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pres_sync <= 2'b00;
      r_lock_sync <= 2'b00;
      r_blk_sync  <= 2'b00;
    end else begin
      r_pres_sync <= {r_pres_sync[0], ~sfp_npres};
      r_lock_sync <= {r_lock_sync[0], pll_locked};
      r_blk_sync  <= {r_blk_sync[0], rx_block_lock};
    end
  end

  assign w_present = r_pres_sync[1];

`ifdef TAXI_SFP_CTRL_LOS_CHECK_EN
  logic [1:0] r_los_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_los_sync <= 2'b00;
    else        r_los_sync <= {r_los_sync[0], sfp_los};
  end

  assign w_ok = r_lock_sync[1] & r_blk_sync[1] & ~r_los_sync[1];
`else
  logic w_unused_los;
  assign w_unused_los = sfp_los;
  assign w_ok = r_lock_sync[1] & r_blk_sync[1];
`endif

  assign w_cnt_zero = (r_cnt == 32'd0);

  // Abort (disable or module pulled) outranks every timer and lock event.
  always_comb begin
    w_state_nxt = r_state;
    w_fault_inc = 1'b0;
    if (r_state != ST_IDLE && (!enable || !w_present)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (enable && w_present) w_state_nxt = ST_DEBOUNCE;
        ST_DEBOUNCE:  if (w_cnt_zero) w_state_nxt = ST_TX_EN;
        ST_TX_EN:     if (w_cnt_zero) w_state_nxt = ST_XCVR_RST;
        ST_XCVR_RST:  if (w_cnt_zero) w_state_nxt = ST_LOCK_WAIT;
        ST_LOCK_WAIT: begin
          if (w_ok) begin
            w_state_nxt = ST_LINK_UP;
          end else if (w_cnt_zero) begin
            w_state_nxt = ST_HOLDOFF;
            w_fault_inc = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (!w_ok) begin
            w_state_nxt = ST_HOLDOFF;
            w_fault_inc = 1'b1;
          end
        end
        ST_HOLDOFF:   if (w_cnt_zero) w_state_nxt = ST_XCVR_RST;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counter reloads on every state change so each timed state dwells PARAM cycles.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_DEBOUNCE:  w_cnt_nxt = c_deb_load;
        ST_TX_EN:     w_cnt_nxt = c_tx_load;
        ST_XCVR_RST:  w_cnt_nxt = c_rst_load;
        ST_LOCK_WAIT: w_cnt_nxt = c_lock_load;
        ST_HOLDOFF:   w_cnt_nxt = c_retry_load;
        default:      w_cnt_nxt = 32'd0;
      endcase
    end else if (!w_cnt_zero) begin
      w_cnt_nxt = r_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs decode the current state register, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_disable  <= 1'b1;
      r_xcvr_rst    <= 1'b1;
      r_link_up     <= 1'b0;
      r_mod_present <= 1'b0;
      r_sfp_rs      <= 2'd0;
      r_fault       <= 8'd0;
    end else begin
      r_tx_disable  <= (r_state == ST_IDLE) || (r_state == ST_DEBOUNCE);
      r_xcvr_rst    <= !((r_state == ST_LOCK_WAIT) || (r_state == ST_LINK_UP));
      r_link_up     <= (r_state == ST_LINK_UP);
      r_mod_present <= (r_state != ST_IDLE) && (r_state != ST_DEBOUNCE);
      if (r_state == ST_IDLE) r_sfp_rs <= rate_sel;
      if (w_fault_inc && (r_fault != 8'hff)) r_fault <= r_fault + 8'd1;
    end
  end

  assign sfp_tx_disable = r_tx_disable;
  assign sfp_rs         = r_sfp_rs;
  assign xcvr_rst       = r_xcvr_rst;
  assign link_up        = r_link_up;
  assign state          = r_state;
  assign fault_cnt      = r_fault;
  assign led            = {r_mod_present, r_link_up};

endmodule
`default_nettype wire
